// File: rtl/muldiv_ctl.sv
// Iterative 32x32 multiply / divide unit with IDLE/RUN/DONE sequencing and pipeline stall.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
module muldiv_ctl #(
  parameter int CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_req,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic        busy_d, done_d;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_step;
  logic [31:0] b_q;
  logic        op_div;
  logic        neg_lo, neg_hi;
  logic [31:0] a_mag, b_mag;
  logic        accept, div0, last, load;
  logic [32:0] mul_sum, rem_sh, rem_diff;
  logic        rem_ge;
  logic [31:0] hi_res, lo_res;

  assign accept = start & ~flush & ((state == IDLE) | (state == DONE));
  assign div0   = op[0] & (b == 32'h0);
  assign last   = (cnt == 6'(CYCLES - 1));
  assign load   = (state == RUN) & last & ~flush;
  assign stall  = (state == RUN) & (start | rd_req);

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  assign a_neg = op[1] & a[31];
  assign b_neg = op[1] & b[31];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [63:0] neg64_if(input logic n, input logic [63:0] v);
    return n ? -v : v;
  endfunction
`else
  logic unused_sign;
  assign unused_sign = op[1];
  assign a_mag = a;
  assign b_mag = b;
`endif

  // One iteration: shift-add for multiply, shift-subtract-restore for divide
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'h0);
    rem_sh   = acc[63:31];
    rem_diff = rem_sh - {1'b0, b_q};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    if (!op_div)
      acc_step = {mul_sum, acc[31:1]};
    else if (rem_ge)
      acc_step = {rem_diff[31:0], acc[30:0], 1'b1};
    else
      acc_step = {rem_sh[31:0], acc[30:0], 1'b0};
  end

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    if (!op_div) begin
      {hi_res, lo_res} = neg64_if(neg_lo, acc_step);
    end else begin
      hi_res = neg_if(neg_hi, acc_step[63:32]);
      lo_res = neg_if(neg_lo, acc_step[31:0]);
    end
`else
    {hi_res, lo_res} = acc_step;
`endif
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = div0 ? DONE : RUN;
        RUN:     if (last)  state_nx = DONE;
        DONE:    state_nx = start ? (div0 ? DONE : RUN) : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_nx == RUN);
    done_d = (state_nx == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= 6'd0;
      hi    <= 32'h0;
      lo    <= 32'h0;
    end else begin
      state <= state_nx;
      busy  <= busy_d;
      done  <= done_d;
      if (accept)
        cnt <= 6'd0;
      else if (state == RUN)
        cnt <= cnt + 6'd1;
      if (load) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (accept && div0) begin
        hi <= a;
        lo <= 32'hFFFF_FFFF;
      end
    end
  end

  // Operand and accumulator datapath
  always_ff @(posedge clk) begin
    if (accept) begin
      acc    <= {32'h0, a_mag};
      b_q    <= b_mag;
      op_div <= op[0];
`ifdef MULDIV_SIGNED_EN
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= a_neg;
`else
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
`endif
    end else if (state == RUN) begin
      acc <= acc_step;
    end
  end

`ifndef MULDIV_SIGNED_EN
  logic unused_neg;
  assign unused_neg = neg_lo ^ neg_hi;
`endif

endmodule

// File: tb/tb_muldiv_ctl.sv
// Self-checking bench for muldiv_ctl: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_muldiv_ctl;
  localparam int CYCLES = 32;
  localparam int LAT    = CYCLES + 2;

  logic        clk = 1'b0;
  logic        rst_n, start, rd_req, flush;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_ctl #(.CYCLES(CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .rd_req(rd_req), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] ma, input logic [31:0] mb);
    logic sgn;
    longint sa, sb, q, r;
    longint unsigned ua, ub;
`ifdef MULDIV_SIGNED_EN
    sgn = m_op[1];
`else
    sgn = 1'b0;
`endif
    ua = {32'h0, ma};
    ub = {32'h0, mb};
    sa = sgn ? longint'($signed(ma)) : longint'(ua);
    sb = sgn ? longint'($signed(mb)) : longint'(ub);
    if (!m_op[0])
      return 64'(sa * sb);
    if (mb == 32'h0)
      return {ma, 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic start_op(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb);
    op = t_op; a = ta; b = tb; start = 1'b1;
  endtask

  // Lets the start-accept edge pass, then waits for done; returns the cycle done was seen in.
  task automatic wait_done(output int cyc);
    @(posedge clk) #1;
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 200) begin
      @(posedge clk) #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 0; rd_req = 1; flush = 0; op = 0; a = 0; b = 0;
    #12;
    n_cmp++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      n_err++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL idle_no_stall: stall=%b busy=%b want 0 0", stall, busy);
    end
    rd_req = 0;
  endtask

  task automatic test_mul_basic;
    int cyc;
    start_op(2'b00, 32'h0001_0000, 32'h0001_0000);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 34 || hi !== 32'h1 || lo !== 32'h0) begin
      n_err++; $display("FAIL mul_basic: cyc=%0d hi=%h lo=%h want 34 00000001 00000000", cyc, hi, lo);
    end
    @(posedge clk) #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_div_stall;
    int cyc, run_cycles, no_stall;
    run_cycles = 0; no_stall = 0;
    start_op(2'b01, 32'd100, 32'd7);
    rd_req = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    cyc = 2;
    while (!done && cyc < 200) begin
      if (busy) begin
        run_cycles++;
        if (stall !== 1'b1) no_stall++;
      end
      @(posedge clk) #1;
      cyc++;
    end
    n_cmp++;
    if (run_cycles !== CYCLES || no_stall !== 0) begin
      n_err++; $display("FAIL div_stall: run=%0d unstalled=%0d want %0d 0", run_cycles, no_stall, CYCLES);
    end
    n_cmp++;
    if (lo !== 32'd14 || hi !== 32'd2 || cyc !== LAT) begin
      n_err++; $display("FAIL div_100_7: cyc=%0d lo=%0d hi=%0d want %0d 14 2", cyc, lo, hi, LAT);
    end
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL done_no_stall: stall=%b want 0", stall);
    end
    rd_req = 1'b0;
    @(posedge clk) #1;
  endtask

  task automatic test_div0;
    int cyc;
    start_op(2'b01, 32'h1234, 32'h0);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== 2 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin
      n_err++; $display("FAIL div0: cyc=%0d hi=%h lo=%h want 2 00001234 ffffffff", cyc, hi, lo);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_flush;
    int cyc, done_seen;
    start_op(2'b01, 32'd47, 32'd7);
    wait_done(cyc);
    @(posedge clk) #1;
    start_op(2'b00, 32'd3, 32'd3);
    @(posedge clk) #1;
    start = 1'b0;
    repeat (9) @(posedge clk) #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL flush_pre_busy: busy=%b want 1", busy);
    end
    flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd5 || lo !== 32'd6) begin
      n_err++; $display("FAIL flush: busy=%b done=%b hi=%0d lo=%0d want 0 0 5 6", busy, done, hi, lo);
    end
    done_seen = 0;
    repeat (40) begin
      @(posedge clk) #1;
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0 || hi !== 32'd5 || lo !== 32'd6) begin
      n_err++; $display("FAIL flush_no_done: dones=%0d hi=%0d lo=%0d want 0 5 6", done_seen, hi, lo);
    end
    // Flush must win over a simultaneous start
    start_op(2'b00, 32'd9, 32'd9);
    flush = 1'b1;
    @(posedge clk) #1;
    start = 1'b0; flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL flush_beats_start: busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] exp;
    start_op(2'b00, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done(cyc);
    start_op(2'b01, 32'hFFFF_FFF0, 32'd3);
    @(posedge clk) #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL b2b_enter_run: busy=%b done=%b want 1 0", busy, done);
    end
    cyc = 2;
    while (!done && cyc < 200) begin
      @(posedge clk) #1;
      cyc++;
    end
    exp = model(2'b01, 32'hFFFF_FFF0, 32'd3);
    n_cmp++;
    if (cyc !== LAT || {hi, lo} !== exp) begin
      n_err++; $display("FAIL b2b_result: cyc=%0d hi=%h lo=%h want %0d %h", cyc, hi, lo, LAT, exp);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_reset_mid;
    int cyc;
    start_op(2'b00, 32'd11, 32'd13);
    @(posedge clk) #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_err++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    start_op(2'b00, 32'd11, 32'd13);
    wait_done(cyc);
    n_cmp++;
    if (cyc !== LAT || hi !== 32'h0 || lo !== 32'd143) begin
      n_err++; $display("FAIL after_reset: cyc=%0d hi=%h lo=%0d want %0d 0 143", cyc, hi, lo, LAT);
    end
    @(posedge clk) #1;
  endtask

  task automatic test_random;
    int cyc, want_cyc;
    logic [1:0]  r_op;
    logic [31:0] ra, rb;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      ra   = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 1000);
      exp      = model(r_op, ra, rb);
      want_cyc = (r_op[0] && rb == 32'h0) ? 2 : LAT;
      start_op(r_op, ra, rb);
      wait_done(cyc);
      n_cmp++;
      if (cyc !== want_cyc || {hi, lo} !== exp) begin
        n_err++;
        $display("FAIL random[%0d] op=%b a=%h b=%h: cyc=%0d hi=%h lo=%h want %0d %h",
                 i, r_op, ra, rb, cyc, hi, lo, want_cyc, exp);
      end
      if ($urandom_range(0, 1) == 0) @(posedge clk) #1;
    end
    @(posedge clk) #1;
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed;
    int cyc;
    start_op(2'b11, -32'sd7, 32'sd2);
    wait_done(cyc);
    n_cmp++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF || cyc !== LAT) begin
      n_err++; $display("FAIL signed_div: cyc=%0d hi=%h lo=%h want %0d ffffffff fffffffd", cyc, hi, lo, LAT);
    end
    @(posedge clk) #1;
    start_op(2'b10, -32'sd3, 32'sd4);
    wait_done(cyc);
    n_cmp++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF4 || cyc !== LAT) begin
      n_err++; $display("FAIL signed_mul: cyc=%0d hi=%h lo=%h want %0d ffffffff fffffff4", cyc, hi, lo, LAT);
    end
    @(posedge clk) #1;
  endtask
`endif

  initial begin
    test_reset();
    test_mul_basic();
    test_div_stall();
    test_div0();
    test_flush();
    test_back_to_back();
    test_reset_mid();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/muldiv_ctl.md
MULDIV_CTL -- requirements
Module: muldiv_ctl

Interface
REQ-001 SHALL have parameter CYCLES, default 32, giving the iteration count per operation; legal range 1..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation from the EX stage.
REQ-005 SHALL have port op  input  2  op[0]: 0=multiply, 1=divide; op[1]: 1=signed (see Configuration).
REQ-006 SHALL have port a  input  32  operand A (multiplicand/dividend), sampled when start is accepted.
REQ-007 SHALL have port b  input  32  operand B (multiplier/divisor), sampled when start is accepted.
REQ-008 SHALL have port rd_req  input  1  EX stage wants to read hi or lo (mfhi/mflo) this cycle.
REQ-009 SHALL have port flush  input  1  pipeline flush; aborts any in-flight operation.
REQ-010 SHALL have port busy  output  1  registered; high in RUN.
REQ-011 SHALL have port stall  output  1  combinational pipeline stall request.
REQ-012 SHALL have port done  output  1  registered one-cycle result pulse.
REQ-013 SHALL have port hi  output  32  registered; product[63:32] or remainder.
REQ-014 SHALL have port lo  output  32  registered; product[31:0] or quotient.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL accept start when the state is IDLE or DONE and flush=0: latch a, b, op, clear the iteration counter, go to RUN.
REQ-017 SHALL, in RUN, perform one shift-add (multiply) or shift-subtract-restore (divide) step per cycle on a 64-bit internal accumulator.
REQ-018 SHALL leave RUN after exactly CYCLES steps, load hi/lo from the accumulator on that edge, and enter DONE; for CYCLES=32, done is high in the 34th cycle counting the start-accept cycle as cycle 1.
REQ-019 SHALL assert done only in DONE; DONE returns to IDLE next cycle unless a new start is accepted (back-to-back start allowed).
REQ-020 SHALL, for divide with b=0, skip RUN: go IDLE->DONE in one cycle with lo=32'hFFFFFFFF, hi=a.
REQ-021 SHALL drive stall = (state==RUN) & (start | rd_req); start or rd_req ignored while RUN is held by the pipeline and re-presented.
REQ-022 SHALL hold hi/lo stable except on the RUN->DONE or divide-by-zero load edge.
REQ-023 SHALL, on flush in any state, go to IDLE next edge, deassert busy/done, leave hi/lo unchanged; flush wins over a simultaneous start.
REQ-024 SHALL compute multiply as the full 64-bit product and divide as truncating quotient/remainder; no overflow flag.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, independent of clk.
REQ-026 SHALL abort an in-flight operation on reset assertion; the first start after rst_n rises is accepted normally.

Configuration
REQ-027 SHALL, with macro MULDIV_SIGNED_EN defined, support signed operation when op[1]=1: operands converted to magnitude at accept, product negated if signs differ, quotient negated if signs differ, remainder takes sign of a; correction applied on the load edge, latency unchanged.
REQ-028 SHALL, without MULDIV_SIGNED_EN, ignore op[1] and treat all operations as unsigned, with no sign-correction logic synthesized.

Verification
REQ-029 SHALL cover: start, op=00, a=32'h0001_0000, b=32'h0001_0000 -> done in cycle 34, hi=32'h1, lo=0.
REQ-030 SHALL cover: start, op=01, a=100, b=7 -> lo=14, hi=2; rd_req during RUN -> stall=1 every RUN cycle.
REQ-031 SHALL cover: start, op=01, a=32'h1234, b=0 -> done next cycle, lo=32'hFFFFFFFF, hi=32'h1234.
REQ-032 SHALL cover: flush at RUN cycle 10 with prior hi=5, lo=6 -> IDLE next edge, busy=0, no done, hi=5, lo=6.
REQ-033 SHALL cover: start in DONE cycle -> new RUN entered without passing through IDLE; rst_n low mid-RUN -> busy=0, hi=lo=0 immediately.
REQ-034 SHALL cover, with MULDIV_SIGNED_EN: op=11, a=-7, b=2 -> lo=-3, hi=-1; op=10, a=-3, b=4 -> hi=32'hFFFFFFFF, lo=-12.
